// File: rtl/bcd_time_counter.sv
// bcd_time_counter: 24-hour HH:MM:SS counter with six registered BCD digit
// outputs, a 1 Hz prescaler and a RUN / SET_H / SET_M mode FSM for setting
// the time.
//
// Parameters:
//   CLK_DIV   clock cycles per one-second tick (>= 2)
// Ports:
//   CLK                 system clock
//   RST                 synchronous reset, active-high
//   MODE                single-cycle pulse, advances RUN -> SET_H -> SET_M -> RUN
//   INC                 single-cycle pulse, increments the field being set
//   SEC_L/SEC_H         seconds ones/tens digit (BCD)
//   MIN_L/MIN_H         minutes ones/tens digit (BCD)
//   HOUR_L/HOUR_H       hours ones/tens digit (BCD)
//   SET_H_ACT/SET_M_ACT high while setting hours/minutes
//   TICK                one-cycle pulse marking a seconds increment
module bcd_time_counter #(
  parameter int unsigned CLK_DIV = 50000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       MODE,
  input  logic       INC,
  output logic [3:0] SEC_L,
  output logic [3:0] SEC_H,
  output logic [3:0] MIN_L,
  output logic [3:0] MIN_H,
  output logic [3:0] HOUR_L,
  output logic [3:0] HOUR_H,
  output logic       SET_H_ACT,
  output logic       SET_M_ACT,
  output logic       TICK
);

  localparam int unsigned PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] presc;

  logic run_cnt_c;
  logic tick_c;
  logic hour_inc_c;
  logic min_inc_c;
  logic sec_clr_c;

  // Next hours value {tens, ones}; 23 wraps to 00.
  function automatic logic [7:0] hour_next(input logic [3:0] h, input logic [3:0] l);
    logic [7:0] r;
    if (h >= 4'd2 && l >= 4'd3) r = 8'h00;
    else if (l >= 4'd9)         r = {h + 4'd1, 4'd0};
    else                        r = {h, l + 4'd1};
    return r;
  endfunction

  // Next minutes value {tens, ones}; 59 wraps to 00.
  function automatic logic [7:0] min_next(input logic [3:0] h, input logic [3:0] l);
    logic [7:0] r;
    if (l >= 4'd9) r = (h >= 4'd5) ? 8'h00 : {h + 4'd1, 4'd0};
    else           r = {h, l + 4'd1};
    return r;
  endfunction

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= RUN;
    else     state <= state_nxt;
  end

  // Next state and per-cycle control strobes; MODE always takes priority over INC.
  always_comb begin
    state_nxt  = state;
    run_cnt_c  = 1'b0;
    tick_c     = 1'b0;
    hour_inc_c = 1'b0;
    min_inc_c  = 1'b0;
    sec_clr_c  = 1'b0;
    case (state)
      RUN: begin
        if (MODE) begin
          state_nxt = SET_H;
        end else begin
          run_cnt_c = 1'b1;
          tick_c    = (presc == PRE_MAX);
        end
      end
      SET_H: begin
        if (MODE) state_nxt  = SET_M;
        else      hour_inc_c = INC;
      end
      SET_M: begin
        if (MODE) begin
          state_nxt = RUN;
          sec_clr_c = 1'b1;
        end else begin
          min_inc_c = INC;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Prescaler, registered flags and time digits.
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc     <= '0;
      TICK      <= 1'b0;
      SET_H_ACT <= 1'b0;
      SET_M_ACT <= 1'b0;
      SEC_L     <= 4'd0;
      SEC_H     <= 4'd0;
      MIN_L     <= 4'd0;
      MIN_H     <= 4'd0;
      HOUR_L    <= 4'd0;
      HOUR_H    <= 4'd0;
    end else begin
      TICK      <= tick_c;
      SET_H_ACT <= (state_nxt == SET_H);
      SET_M_ACT <= (state_nxt == SET_M);
      // Prescaler only runs in RUN; any mode change restarts the second.
      if (run_cnt_c && !tick_c) presc <= presc + PW'(1);
      else                      presc <= '0;

      if (tick_c) begin
        // Full BCD ripple resolved within one edge.
        if (SEC_L != 4'd9) begin
          SEC_L <= SEC_L + 4'd1;
        end else begin
          SEC_L <= 4'd0;
          if (SEC_H != 4'd5) begin
            SEC_H <= SEC_H + 4'd1;
          end else begin
            SEC_H <= 4'd0;
            {MIN_H, MIN_L} <= min_next(MIN_H, MIN_L);
            if (MIN_H == 4'd5 && MIN_L == 4'd9)
              {HOUR_H, HOUR_L} <= hour_next(HOUR_H, HOUR_L);
          end
        end
      end else if (hour_inc_c) begin
        {HOUR_H, HOUR_L} <= hour_next(HOUR_H, HOUR_L);
      end else if (min_inc_c) begin
        {MIN_H, MIN_L} <= min_next(MIN_H, MIN_L);
      end else if (sec_clr_c) begin
        SEC_L <= 4'd0;
        SEC_H <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_bcd_time_counter.sv
// Testbench for bcd_time_counter (CLK_DIV = 4): reset/startup vector table,
// hand-written setting and wrap sequences, then random MODE/INC/RST traffic
// checked against a seconds-of-day reference model.
module tb_bcd_time_counter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       MODE = 1'b0;
  logic       INC = 1'b0;
  logic [3:0] SEC_L, SEC_H, MIN_L, MIN_H, HOUR_L, HOUR_H;
  logic       SET_H_ACT, SET_M_ACT, TICK;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: time as seconds of day, mode 0=RUN 1=SET_H 2=SET_M.
  int   m_t = 0;
  int   m_mode = 0;
  int   m_cnt = 0;
  logic m_tick = 1'b0;

  typedef struct {
    logic rst;
    logic mode;
    logic inc;
    int   t;
    logic tick;
  } vec_t;

  vec_t vecs[14];

  bcd_time_counter #(.CLK_DIV(4)) dut (
    .CLK(CLK), .RST(RST), .MODE(MODE), .INC(INC),
    .SEC_L(SEC_L), .SEC_H(SEC_H), .MIN_L(MIN_L), .MIN_H(MIN_H),
    .HOUR_L(HOUR_L), .HOUR_H(HOUR_H),
    .SET_H_ACT(SET_H_ACT), .SET_M_ACT(SET_M_ACT), .TICK(TICK)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t mkv(input logic r, input int t, input logic tk);
    vec_t v;
    v.rst = r; v.mode = 1'b0; v.inc = 1'b0; v.t = t; v.tick = tk;
    return v;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic exp_check(input string name, input int t, input logic sh,
                           input logic sm, input logic tk);
    int h, mi, s;
    h = t / 3600; mi = (t / 60) % 60; s = t % 60;
    cmp({name, ".sec_l"},  int'(SEC_L),  s % 10);
    cmp({name, ".sec_h"},  int'(SEC_H),  s / 10);
    cmp({name, ".min_l"},  int'(MIN_L),  mi % 10);
    cmp({name, ".min_h"},  int'(MIN_H),  mi / 10);
    cmp({name, ".hour_l"}, int'(HOUR_L), h % 10);
    cmp({name, ".hour_h"}, int'(HOUR_H), h / 10);
    cmp({name, ".set_h"},  int'(SET_H_ACT), int'(sh));
    cmp({name, ".set_m"},  int'(SET_M_ACT), int'(sm));
    cmp({name, ".tick"},   int'(TICK), int'(tk));
  endtask

  task automatic model_update(input logic r, input logic m, input logic i);
    if (r) begin
      m_t = 0; m_mode = 0; m_cnt = 0; m_tick = 1'b0;
    end else begin
      m_tick = 1'b0;
      case (m_mode)
        0: begin
          if (m) begin
            m_mode = 1; m_cnt = 0;
          end else if (m_cnt == 3) begin
            m_t = (m_t + 1) % 86400; m_cnt = 0; m_tick = 1'b1;
          end else begin
            m_cnt++;
          end
        end
        1: begin
          m_cnt = 0;
          if (m) m_mode = 2;
          else if (i) m_t = (((m_t / 3600) + 1) % 24) * 3600 + (m_t % 3600);
        end
        default: begin
          m_cnt = 0;
          if (m) begin
            m_mode = 0; m_t = m_t - (m_t % 60);
          end else if (i) begin
            m_t = (m_t / 3600) * 3600 + ((((m_t / 60) % 60) + 1) % 60) * 60 + (m_t % 60);
          end
        end
      endcase
    end
  endtask

  // One clock: drive inputs, advance model, sample #1 after the edge, check BCD legality.
  task automatic step(input logic r, input logic m, input logic i);
    logic legal;
    RST = r; MODE = m; INC = i;
    @(posedge CLK);
    model_update(r, m, i);
    #1;
    legal = (SEC_L <= 4'd9) && (SEC_H <= 4'd5) && (MIN_L <= 4'd9) && (MIN_H <= 4'd5) &&
            (HOUR_H <= 4'd2) && ((HOUR_H < 4'd2) ? (HOUR_L <= 4'd9) : (HOUR_L <= 4'd3));
    cmp("bcd_legal", int'(legal), 1);
  endtask

  task automatic check_model(input string name);
    exp_check(name, m_t, (m_mode == 1), (m_mode == 2), m_tick);
  endtask

  initial begin
    // Reset for 2 cycles, then ticks on the 4th, 8th, 12th cycle after release.
    vecs[0]  = mkv(1'b1, 0, 1'b0);
    vecs[1]  = mkv(1'b1, 0, 1'b0);
    vecs[2]  = mkv(1'b0, 0, 1'b0);
    vecs[3]  = mkv(1'b0, 0, 1'b0);
    vecs[4]  = mkv(1'b0, 0, 1'b0);
    vecs[5]  = mkv(1'b0, 1, 1'b1);
    vecs[6]  = mkv(1'b0, 1, 1'b0);
    vecs[7]  = mkv(1'b0, 1, 1'b0);
    vecs[8]  = mkv(1'b0, 1, 1'b0);
    vecs[9]  = mkv(1'b0, 2, 1'b1);
    vecs[10] = mkv(1'b0, 2, 1'b0);
    vecs[11] = mkv(1'b0, 2, 1'b0);
    vecs[12] = mkv(1'b0, 2, 1'b0);
    vecs[13] = mkv(1'b0, 3, 1'b1);
    for (int k = 0; k < 14; k++) begin
      step(vecs[k].rst, vecs[k].mode, vecs[k].inc);
      exp_check($sformatf("vec%0d", k), vecs[k].t, 1'b0, 1'b0, vecs[k].tick);
    end

    // Preload 23:59 via SET, run 60 ticks across midnight.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 23; k++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 59; k++) step(1'b0, 1'b0, 1'b1);
    exp_check("preload_setm", 23 * 3600 + 59 * 60, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    exp_check("preload_run", 23 * 3600 + 59 * 60, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 59 * 4; k++) step(1'b0, 1'b0, 1'b0);
    exp_check("at_235959", 86399, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0);
    exp_check("midnight_wrap", 0, 1'b0, 1'b0, 1'b1);

    // Hours set with wrap at 24; seconds untouched, no TICK while setting.
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 25; k++) begin
      step(1'b0, 1'b0, 1'b1);
      cmp("no_tick_set_h", int'(TICK), 0);
    end
    exp_check("set_h_wrap", 3600 + 2, 1'b1, 1'b0, 1'b0);

    // Minutes set with wrap at 60, no carry; exit clears seconds, tick 4 cycles later.
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 61; k++) step(1'b0, 1'b0, 1'b1);
    exp_check("set_m_wrap", 3600 + 60 + 2, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    exp_check("exit_run", 3600 + 60, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0);
      cmp("tick_early", int'(TICK), 0);
    end
    step(1'b0, 1'b0, 1'b0);
    exp_check("first_tick", 3600 + 61, 1'b0, 1'b0, 1'b1);

    // MODE and INC together in SET_H: MODE wins.
    step(1'b0, 1'b1, 1'b0);
    exp_check("enter_set_h", 3600 + 61, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    exp_check("mode_wins", 3600 + 61, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    exp_check("back_run", 3600 + 60, 1'b0, 1'b0, 1'b0);

    // Reset one cycle before a tick at 12:34:56.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 34; k++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 56 * 4 + 3; k++) step(1'b0, 1'b0, 1'b0);
    exp_check("pre_reset", 12 * 3600 + 34 * 60 + 56, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    exp_check("mid_reset", 0, 1'b0, 1'b0, 1'b0);

    // Random traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 2) == 0));
      check_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_time_counter.md
Name: bcd_time_counter

Overview:
24-hour time-of-day counter producing six BCD digits (HH:MM:SS) that feed the per-digit seven-segment decoders directly. A parameterised prescaler derives a 1 Hz count enable from the board clock. A small mode FSM driven by two pre-debounced single-cycle key pulses allows setting hours and minutes. All digit outputs are registered and always hold legal BCD (0-9), so the downstream decoders never blank a digit.

Parameters:
CLK_DIV, 50000000, CLK cycles per one-second tick; minimum 2; prescaler width = clog2(CLK_DIV).

Ports:
CLK  in  1  system clock.
RST  in  1  synchronous reset, active-high.
MODE  in  1  single-cycle pulse; advances mode FSM.
INC  in  1  single-cycle pulse; increments the field being set.
SEC_L  out  4  seconds ones digit, BCD 0-9.
SEC_H  out  4  seconds tens digit, BCD 0-5.
MIN_L  out  4  minutes ones digit, BCD 0-9.
MIN_H  out  4  minutes tens digit, BCD 0-5.
HOUR_L  out  4  hours ones digit, BCD 0-9 (0-3 when HOUR_H=2).
HOUR_H  out  4  hours tens digit, BCD 0-2.
SET_H_ACT  out  1  high while in SET_H (for display blink).
SET_M_ACT  out  1  high while in SET_M.
TICK  out  1  one-cycle pulse marking a seconds increment.

Behaviour:
- Clocking: one clock (CLK). Reset is synchronous and active-high (RST); sampled on the rising edge of CLK only.
- Reset: all six digits 0 (00:00:00), state RUN, prescaler 0, TICK 0, SET_H_ACT 0, SET_M_ACT 0.
- Prescaler: in RUN, counts 0..CLK_DIV-1 and then wraps to 0. On the edge where the count equals CLK_DIV-1, the seconds increment applies and TICK is registered high for exactly the following cycle. Period is exactly CLK_DIV cycles. In SET_H and SET_M, the prescaler is held at 0 and TICK stays 0.
- Time increment (RUN, on tick): BCD ripple within a single edge.
  - SEC_L 9->0 carries into SEC_H.
  - SEC_H:SEC_L 59->00 carries into minutes.
  - Minutes 59->00 carries into hours.
  - Hours 23->00 (HOUR_L 9->0 with HOUR_H+1; 23 wraps to 00).
  - 23:59:59 -> 00:00:00 in one edge.
  - No intermediate illegal value is ever visible.
- FSM states: RUN, SET_H, SET_M.
  - RUN --MODE--> SET_H.
  - SET_H --MODE--> SET_M.
  - SET_M --MODE--> RUN. On this transition, seconds are cleared to 00 and the prescaler to 0, so the first tick arrives CLK_DIV cycles after re-entering RUN.
  - SET_H_ACT and SET_M_ACT are Moore outputs of the registered state.
- INC handling:
  - In SET_H: hours +1, 23->00, no effect on minutes or seconds.
  - In SET_M: minutes +1, 59->00, no carry into hours.
  - In RUN: ignored.
  - The update is visible the cycle after the INC pulse.
- Seconds hold their value while in SET_H and SET_M.
- Simultaneous MODE and INC: MODE wins; INC is dropped that cycle.
- MODE/INC held high for multiple cycles: each high cycle counts as a separate pulse. Debouncing and edge detection are done upstream.
- RST asserted mid-operation, in any state and any prescaler phase: next edge gives the full reset state; a TICK in flight is suppressed.
- No illegal state: unreachable FSM encodings return to RUN. Any digit value outside its legal range is never produced.

Test Plan:
- CLK_DIV=4, RST for 2 cycles then release -> digits 000000, TICK 0. TICK pulses on cycles 4, 8, 12, ... after release. SEC_L reads 1, 2, 3 after successive ticks.
- Preload via SET to 23:59, exit to RUN, run 60 ticks -> time passes 23:59:59, then reads 00:00:00 exactly one tick later. All digits are legal BCD on every cycle (assertion).
- MODE once, INC x25 -> HOUR_H:HOUR_L = 01 (wrap at 24), minutes and seconds unchanged, SET_H_ACT=1, no TICK during SET.
- MODE twice, INC x61 at minutes=00 -> minutes 01, hours unchanged. A third MODE -> RUN with seconds 00. First TICK arrives exactly 4 cycles later.
- MODE and INC high in the same cycle while in SET_H -> state becomes SET_M, hours unchanged.
- RST asserted one cycle before a TICK while the time is 12:34:56 -> next cycle shows 00:00:00, TICK 0, state RUN.
